// File: rtl/systolic_scheduler.sv
// Sequencer for one systolic GEMM pass: loads W and X from memory into row buffers,
// streams one row per cycle into the array, then writes the captured result block back.
module systolic_scheduler #(
    parameter int M          = 1,
    parameter int N          = 27,
    parameter int K          = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] WEIGHT_BASE = 'h1000,
    parameter logic [ADDR_WIDTH-1:0] IM2COL_BASE = 'h2000,
    parameter logic [ADDR_WIDTH-1:0] OUTPUT_BASE = 'h3000
) (
    input  logic                         clk,
    input  logic                         rst_systolic,
    input  logic                         start,
    output logic [ADDR_WIDTH-1:0]        mem_addr_rd,
    input  logic [DATA_WIDTH-1:0]        mem_data_rd,
    output logic [ADDR_WIDTH-1:0]        mem_addr_wr,
    output logic [DATA_WIDTH-1:0]        mem_data_wr,
    output logic                         mem_wr_en,
    output logic                         sa_rst_n,
    output logic [DATA_WIDTH*M-1:0]      X,
    output logic [DATA_WIDTH*K-1:0]      W,
    input  logic [DATA_WIDTH*M*K-1:0]    Y,
    input  logic                         sa_done,
    output logic                         busy,
    output logic                         done
);

    localparam int MAX_MK = (M > K) ? M : K;
    localparam int CW     = $clog2(N * MAX_MK + 1);
    localparam int NW     = N * K;
    localparam int NX     = N * M;
    localparam int NY     = M * K;
    localparam int WSW    = $clog2(NW * DATA_WIDTH);
    localparam int XSW    = $clog2(NX * DATA_WIDTH);
    localparam int YSW    = $clog2(NY * DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE, LOAD_W, LOAD_X, DRAIN, STREAM, WAIT, STORE, FIN
    } state_t;

    state_t state, state_next;

    logic [CW-1:0] rd_cnt, s_cnt, wr_cnt;
    logic [CW-1:0] row_sel, wr_next;

    logic          tag_valid, tag_is_x;
    logic [CW-1:0] tag_idx;

    logic [NW*DATA_WIDTH-1:0] w_buf, w_buf_d;
    logic [NX*DATA_WIDTH-1:0] x_buf, x_buf_d;
    logic [NY*DATA_WIDTH-1:0] y_q;

    logic [WSW-1:0] w_wr_sel, w_rd_sel;
    logic [XSW-1:0] x_wr_sel, x_rd_sel;
    logic [YSW-1:0] y_sel;

    always_ff @(posedge clk or negedge rst_systolic) begin
        if (!rst_systolic) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LOAD_W;
            LOAD_W:  if (rd_cnt == CW'(NW - 1)) state_next = LOAD_X;
            LOAD_X:  if (rd_cnt == CW'(NX - 1)) state_next = DRAIN;
            DRAIN:   state_next = STREAM;
            STREAM:  if (s_cnt == CW'(N - 1)) state_next = WAIT;
            WAIT:    if (sa_done) state_next = STORE;
            STORE:   if (wr_cnt == CW'(NY - 1)) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_addr_rd = WEIGHT_BASE;
        sa_rst_n    = 1'b0;
        busy        = (state != IDLE);
        done        = (state == FIN);
        case (state)
            LOAD_W:               mem_addr_rd = WEIGHT_BASE + ADDR_WIDTH'(rd_cnt);
            LOAD_X:               mem_addr_rd = IM2COL_BASE + ADDR_WIDTH'(rd_cnt);
            STREAM, WAIT, STORE:  sa_rst_n = 1'b1;
            default: ;
        endcase
    end

    // The buffer next-value doubles as a bypass, so a word landing on the
    // same edge that a row is streamed out is still seen by that row.
    always_comb begin
        row_sel  = (state == DRAIN) ? '0 : s_cnt + 1'b1;
        wr_next  = wr_cnt + 1'b1;
        w_wr_sel = WSW'(tag_idx) * WSW'(DATA_WIDTH);
        x_wr_sel = XSW'(tag_idx) * XSW'(DATA_WIDTH);
        w_rd_sel = WSW'(row_sel) * WSW'(K * DATA_WIDTH);
        x_rd_sel = XSW'(row_sel) * XSW'(M * DATA_WIDTH);
        y_sel    = YSW'(wr_next) * YSW'(DATA_WIDTH);
        w_buf_d  = w_buf;
        x_buf_d  = x_buf;
        if (tag_valid && !tag_is_x) w_buf_d[w_wr_sel +: DATA_WIDTH] = mem_data_rd;
        if (tag_valid && tag_is_x)  x_buf_d[x_wr_sel +: DATA_WIDTH] = mem_data_rd;
    end

    always_ff @(posedge clk) begin
        w_buf <= w_buf_d;
        x_buf <= x_buf_d;
        if (state == WAIT && sa_done) y_q <= Y;
    end

    always_ff @(posedge clk or negedge rst_systolic) begin
        if (!rst_systolic) begin
            rd_cnt      <= '0;
            s_cnt       <= '0;
            wr_cnt      <= '0;
            tag_valid   <= 1'b0;
            tag_is_x    <= 1'b0;
            tag_idx     <= '0;
            X           <= '0;
            W           <= '0;
            mem_wr_en   <= 1'b0;
            mem_addr_wr <= '0;
            mem_data_wr <= '0;
        end else begin
            tag_valid <= (state == LOAD_W) || (state == LOAD_X);
            tag_is_x  <= (state == LOAD_X);
            tag_idx   <= rd_cnt;
            case (state)
                IDLE: rd_cnt <= '0;
                LOAD_W, LOAD_X: begin
                    if (state_next != state) rd_cnt <= '0;
                    else                     rd_cnt <= rd_cnt + 1'b1;
                end
                DRAIN, STREAM: begin
                    if (state_next == WAIT) begin
                        X <= '0;
                        W <= '0;
                    end else begin
                        s_cnt <= row_sel;
                        X     <= x_buf_d[x_rd_sel +: DATA_WIDTH*M];
                        W     <= w_buf_d[w_rd_sel +: DATA_WIDTH*K];
                    end
                end
                WAIT: begin
                    if (sa_done) begin
                        wr_cnt      <= '0;
                        mem_wr_en   <= 1'b1;
                        mem_addr_wr <= OUTPUT_BASE;
                        mem_data_wr <= Y[DATA_WIDTH-1:0];
                    end
                end
                STORE: begin
                    if (wr_cnt == CW'(NY - 1)) begin
                        mem_wr_en <= 1'b0;
                    end else begin
                        wr_cnt      <= wr_next;
                        mem_addr_wr <= OUTPUT_BASE + ADDR_WIDTH'(wr_next);
                        mem_data_wr <= y_q[y_sel +: DATA_WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_scheduler.sv
// Directed bench: default-size scheduler through full, held-start and reset-interrupted passes,
// plus an M=2/K=3/N=4 instance for row packing and result ordering.
module tb_systolic_scheduler;

    logic clk = 1'b0;
    logic rst_systolic;
    always #5 clk = ~clk;

    logic        a_start, a_sa_done, a_mem_wr_en, a_sa_rst_n, a_busy, a_done;
    logic [31:0] a_mem_addr_rd, a_mem_data_rd, a_mem_addr_wr, a_mem_data_wr;
    logic [31:0] a_x;
    logic [63:0] a_w, a_y;

    logic        b_start, b_sa_done, b_mem_wr_en, b_sa_rst_n, b_busy, b_done;
    logic [31:0] b_mem_addr_rd, b_mem_data_rd, b_mem_addr_wr, b_mem_data_wr;
    logic [63:0] b_x;
    logic [95:0] b_w;
    logic [191:0] b_y;

    int pass_cnt = 0;
    int total_cnt = 0;
    int fail_cnt = 0;
    int cyc = 0;
    int a_wr_cnt = 0;
    int a_done_cnt = 0;
    int b_wr_cnt = 0;
    logic [31:0] a_wr_addr [32];
    logic [31:0] a_wr_data [32];
    int          a_wr_cyc  [32];
    logic [31:0] b_wr_addr [32];
    logic [31:0] b_wr_data [32];

    systolic_scheduler dut_a (
        .clk(clk), .rst_systolic(rst_systolic), .start(a_start),
        .mem_addr_rd(a_mem_addr_rd), .mem_data_rd(a_mem_data_rd),
        .mem_addr_wr(a_mem_addr_wr), .mem_data_wr(a_mem_data_wr), .mem_wr_en(a_mem_wr_en),
        .sa_rst_n(a_sa_rst_n), .X(a_x), .W(a_w), .Y(a_y), .sa_done(a_sa_done),
        .busy(a_busy), .done(a_done)
    );

    systolic_scheduler #(.M(2), .N(4), .K(3)) dut_b (
        .clk(clk), .rst_systolic(rst_systolic), .start(b_start),
        .mem_addr_rd(b_mem_addr_rd), .mem_data_rd(b_mem_data_rd),
        .mem_addr_wr(b_mem_addr_wr), .mem_data_wr(b_mem_data_wr), .mem_wr_en(b_mem_wr_en),
        .sa_rst_n(b_sa_rst_n), .X(b_x), .W(b_w), .Y(b_y), .sa_done(b_sa_done),
        .busy(b_busy), .done(b_done)
    );

    // Memory image: W[i] = i+1 at 0x1000, X[i] = 100+i at 0x2000, anything else is poison.
    function automatic logic [31:0] mem_value(input logic [31:0] addr, input int n_w, input int n_x);
        if (addr >= 32'h1000 && addr < 32'h1000 + 32'(n_w)) return addr - 32'h1000 + 32'd1;
        if (addr >= 32'h2000 && addr < 32'h2000 + 32'(n_x)) return addr - 32'h2000 + 32'd100;
        return 32'hDEAD_BEEF;
    endfunction

    always @(posedge clk) begin
        a_mem_data_rd <= mem_value(a_mem_addr_rd, 54, 27);
        b_mem_data_rd <= mem_value(b_mem_addr_rd, 12, 8);
        cyc <= cyc + 1;
        if (a_mem_wr_en && a_wr_cnt < 32) begin
            a_wr_addr[a_wr_cnt] <= a_mem_addr_wr;
            a_wr_data[a_wr_cnt] <= a_mem_data_wr;
            a_wr_cyc[a_wr_cnt]  <= cyc;
            a_wr_cnt            <= a_wr_cnt + 1;
        end
        if (b_mem_wr_en && b_wr_cnt < 32) begin
            b_wr_addr[b_wr_cnt] <= b_mem_addr_wr;
            b_wr_data[b_wr_cnt] <= b_mem_data_wr;
            b_wr_cnt            <= b_wr_cnt + 1;
        end
        if (a_done) a_done_cnt <= a_done_cnt + 1;
    end

    task automatic check_output(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        total_cnt++;
        assert (observed === expected) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Entered on the negedge of the first LOAD_W cycle; walks one full pass of dut_a.
    task automatic walk_pass(input string tag, input bit hold_done, input int extra_wait, input bit abort_store);
        int bad;
        int wr_base;
        int done_base;
        wr_base   = a_wr_cnt;
        done_base = a_done_cnt;
        bad = 0;
        for (int i = 0; i < 54; i++) begin
            if (a_mem_addr_rd !== 32'h1000 + 32'(i) || a_sa_rst_n !== 1'b0 || a_busy !== 1'b1) bad++;
            @(negedge clk);
        end
        for (int i = 0; i < 27; i++) begin
            if (a_mem_addr_rd !== 32'h2000 + 32'(i) || a_sa_rst_n !== 1'b0 || a_busy !== 1'b1) bad++;
            @(negedge clk);
        end
        check_output({tag, " load_trace"}, 256'(bad), 256'd0);
        check_output({tag, " drain_sa_rst"}, 256'(a_sa_rst_n), 256'd0);
        @(negedge clk);
        bad = 0;
        for (int k = 0; k < 27; k++) begin
            if (a_x !== 32'(100 + k) || a_w !== {32'(2*k + 2), 32'(2*k + 1)} || a_sa_rst_n !== 1'b1) bad++;
            if (k == 0) begin
                check_output({tag, " row0_x"}, 256'(a_x), 256'd100);
                check_output({tag, " row0_w"}, 256'(a_w), 256'({32'd2, 32'd1}));
            end
            if (k == 26) begin
                check_output({tag, " row26_x"}, 256'(a_x), 256'd126);
                check_output({tag, " row26_w"}, 256'(a_w), 256'({32'd54, 32'd53}));
            end
            @(negedge clk);
        end
        check_output({tag, " stream_rows"}, 256'(bad), 256'd0);
        check_output({tag, " wait_zero"}, 256'({a_x, a_w, a_sa_rst_n}), 256'd1);
        if (!hold_done) begin
            a_start = 1'b1;
            @(negedge clk);
            a_start = 1'b0;
            repeat (extra_wait - 1) @(negedge clk);
            check_output({tag, " wait_hold"}, 256'({a_x, a_w, a_mem_wr_en, a_busy}), 256'd1);
            a_sa_done = 1'b1;
        end
        @(negedge clk);
        if (!hold_done) a_sa_done = 1'b0;
        check_output({tag, " store0"}, 256'({a_mem_wr_en, a_mem_addr_wr, a_mem_data_wr}),
                     256'({1'b1, 32'h3000, 32'd9}));
        if (abort_store) begin
            @(negedge clk);
            rst_systolic = 1'b0;
            #1;
            check_output({tag, " abort_async"}, 256'({a_mem_wr_en, a_sa_rst_n, a_busy}), 256'd0);
            check_output({tag, " abort_one_write"}, 256'(a_wr_cnt - wr_base), 256'd1);
            return;
        end
        @(negedge clk);
        check_output({tag, " store1"}, 256'({a_mem_wr_en, a_mem_addr_wr, a_mem_data_wr}),
                     256'({1'b1, 32'h3001, 32'd7}));
        @(negedge clk);
        check_output({tag, " fin"}, 256'({a_done, a_busy, a_mem_wr_en, a_sa_rst_n}), 256'(4'b1100));
        @(negedge clk);
        check_output({tag, " idle"}, 256'({a_done, a_busy}), 256'd0);
        check_output({tag, " wr_count"}, 256'(a_wr_cnt - wr_base), 256'd2);
        check_output({tag, " wr_log"}, 256'({a_wr_addr[wr_base], a_wr_data[wr_base],
                     a_wr_addr[wr_base+1], a_wr_data[wr_base+1]}),
                     256'({32'h3000, 32'd9, 32'h3001, 32'd7}));
        check_output({tag, " wr_consecutive"}, 256'(a_wr_cyc[wr_base+1] - a_wr_cyc[wr_base]), 256'd1);
        check_output({tag, " done_once"}, 256'(a_done_cnt - done_base), 256'd1);
    endtask

    initial begin
        int bad;
        int wr_snap;
        rst_systolic = 1'b0;
        a_start = 1'b0;
        a_sa_done = 1'b0;
        a_y = {32'd7, 32'd9};
        b_start = 1'b0;
        b_sa_done = 1'b0;
        for (int i = 0; i < 6; i++) b_y[i*32 +: 32] = 32'(500 + i);

        repeat (2) @(negedge clk);
        check_output("reset_ctrl", 256'({a_busy, a_done, a_sa_rst_n, a_mem_wr_en}), 256'd0);
        check_output("reset_xw", 256'({a_x, a_w}), 256'd0);
        check_output("reset_addr_rd", 256'(a_mem_addr_rd), 256'h1000);
        check_output("reset_wr_bus", 256'({a_mem_addr_wr, a_mem_data_wr}), 256'd0);
        check_output("reset_b", 256'({b_busy, b_x, b_w, b_mem_addr_rd}), 256'h1000);
        rst_systolic = 1'b1;
        @(negedge clk);

        $display("[TB] pass 1: single start pulse, start also pulsed during WAIT");
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        walk_pass("p1", 1'b0, 3, 1'b0);
        @(negedge clk);
        check_output("p1_no_requeue", 256'(a_busy), 256'd0);

        $display("[TB] pass 2: start and sa_done held high throughout");
        a_sa_done = 1'b1;
        a_start = 1'b1;
        @(negedge clk);
        walk_pass("p2", 1'b1, 0, 1'b0);
        @(negedge clk);
        check_output("p3_restart", 256'({a_busy, a_mem_addr_rd}), 256'({1'b1, 32'h1000}));
        a_start = 1'b0;
        a_sa_done = 1'b0;

        $display("[TB] pass 3: reset during LOAD_X");
        repeat (59) @(negedge clk);
        check_output("p3_in_load_x", 256'(a_mem_addr_rd), 256'h2005);
        rst_systolic = 1'b0;
        #1;
        check_output("p3_reset", 256'({a_busy, a_sa_rst_n, a_mem_wr_en, a_mem_addr_rd}), 256'h1000);
        @(negedge clk);
        rst_systolic = 1'b1;
        @(negedge clk);

        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        walk_pass("p4", 1'b0, 1, 1'b0);

        $display("[TB] pass 5: reset after the first result write");
        wr_snap = a_wr_cnt;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        walk_pass("p5", 1'b0, 2, 1'b1);
        @(negedge clk);
        rst_systolic = 1'b1;
        repeat (3) @(negedge clk);
        check_output("p5_no_more_writes", 256'({a_busy, 32'(a_wr_cnt - wr_snap)}), 256'd1);

        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        walk_pass("p6", 1'b0, 1, 1'b0);

        $display("[TB] M=2 K=3 N=4 instance");
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (b_mem_addr_rd !== 32'h1000 + 32'(i)) bad++;
            @(negedge clk);
        end
        for (int i = 0; i < 8; i++) begin
            if (b_mem_addr_rd !== 32'h2000 + 32'(i)) bad++;
            @(negedge clk);
        end
        check_output("b_load_trace", 256'(bad), 256'd0);
        check_output("b_drain_sa_rst", 256'(b_sa_rst_n), 256'd0);
        @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            check_output($sformatf("b_row%0d_x", s), 256'(b_x), 256'({32'(101 + 2*s), 32'(100 + 2*s)}));
            check_output($sformatf("b_row%0d_w", s), 256'(b_w),
                         256'({32'(3*s + 3), 32'(3*s + 2), 32'(3*s + 1)}));
            @(negedge clk);
        end
        check_output("b_wait_zero", 256'({b_x, b_w}), 256'd0);
        b_sa_done = 1'b1;
        @(negedge clk);
        b_sa_done = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if ({b_mem_wr_en, b_mem_addr_wr, b_mem_data_wr} !== {1'b1, 32'h3000 + 32'(i), 32'(500 + i)}) bad++;
            @(negedge clk);
        end
        check_output("b_store_trace", 256'(bad), 256'd0);
        check_output("b_fin", 256'({b_done, b_busy, b_mem_wr_en}), 256'(3'b110));
        @(negedge clk);
        check_output("b_idle", 256'({b_done, b_busy}), 256'd0);
        check_output("b_wr_count", 256'(b_wr_cnt), 256'd6);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (b_wr_addr[i] !== 32'h3000 + 32'(i) || b_wr_data[i] !== 32'(500 + i)) bad++;
        end
        check_output("b_wr_log", 256'(bad), 256'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
